cntdn_ctrl: RTL and testbench

//  Countdown-timer controller that sequences the mm:ss LCD text formatter.

---
 rtl/cntdn_ctrl_if.sv | 23 ++
 rtl/cntdn_ctrl.sv | 171 +++++++++++++++++
 tb/tb_cntdn_ctrl.sv | 204 ++++++++++++++++++++
 3 files changed

// File: rtl/cntdn_ctrl_if.sv
// Button and formatter-facing signals of the countdown controller.
// master drives the buttons; slave is the controller itself.
`timescale 1ns/1ps
interface cntdn_ctrl_if;
  logic        btn_min;
  logic        btn_sec;
  logic        btn_ss;
  logic        btn_clr;
  logic [20:0] num;
  logic [20:0] org;
  logic [1:0]  cState;
  logic        tick;

  modport master (
    output btn_min, btn_sec, btn_ss, btn_clr,
    input  num, org, cState, tick
  );

  modport slave (
    input  btn_min, btn_sec, btn_ss, btn_clr,
    output num, org, cState, tick
  );
endinterface

// File: rtl/cntdn_ctrl.sv
// mm:ss countdown controller: button sync/edge detect, SET/RUN/PAUSE/DONE FSM, 1 Hz prescaler.
// Optional macro CNTDN_AUTORELOAD_EN: DONE restarts the countdown after TICK_DIV cycles.
`timescale 1ns/1ps
module cntdn_ctrl #(
  parameter int TICK_DIV = 50_000_000,
  parameter int MAX_SEC  = 5999
) (
  input  logic          clk,
  input  logic          rst_n,
  cntdn_ctrl_if.slave   bus
);

  localparam logic [1:0] ST_SET   = 2'd0;
  localparam logic [1:0] ST_RUN   = 2'd1;
  localparam logic [1:0] ST_PAUSE = 2'd2;
  localparam logic [1:0] ST_DONE  = 2'd3;

  localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

  // Button bit order: 3=clr, 2=ss, 1=min, 0=sec (also the priority order).
  logic [3:0] btn_raw;
  logic [3:0] sync1_q, sync2_q, prev_q;
  logic [3:0] rise;

  assign btn_raw = {bus.btn_clr, bus.btn_ss, bus.btn_min, bus.btn_sec};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q <= '0;
      sync2_q <= '0;
      prev_q  <= '0;
    end else begin
      sync1_q <= btn_raw;
      sync2_q <= sync1_q;
      prev_q  <= sync2_q;
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_edge
      assign rise[gi] = sync2_q[gi] & ~prev_q[gi];
    end
  endgenerate

  logic act_clr, act_ss, act_min, act_sec;
  assign act_clr = rise[3];
  assign act_ss  = rise[2] & ~rise[3];
  assign act_min = rise[1] & ~(|rise[3:2]);
  assign act_sec = rise[0] & ~(|rise[3:1]);

  logic [1:0]    state_q, state_d;
  logic [20:0]   org_q, org_d;
  logic [5:0]    osec_q, osec_d;
  logic [20:0]   num_q, num_d;
  logic [PW-1:0] presc_q, presc_d;
  logic          tick_q, tick_d;
  logic          presc_wrap;

  assign presc_wrap = (presc_q == PW'(TICK_DIV - 1));

  always_comb begin
    state_d = state_q;
    org_d   = org_q;
    osec_d  = osec_q;
    num_d   = num_q;
    presc_d = presc_q;
    tick_d  = 1'b0;
    case (state_q)
      ST_SET: begin
        presc_d = '0;
        if (act_clr) begin
          org_d  = '0;
          osec_d = '0;
        end else if (act_ss) begin
          if (org_q != '0)
            state_d = ST_RUN;
        end else if (act_min) begin
          // Past the maximum, the minutes field wraps to 0 while seconds survive.
          if (org_q + 21'd60 > 21'(MAX_SEC))
            org_d = {15'd0, osec_q};
          else
            org_d = org_q + 21'd60;
        end else if (act_sec) begin
          if (osec_q == 6'd59) begin
            org_d  = org_q - 21'd59;
            osec_d = '0;
          end else begin
            org_d  = org_q + 21'd1;
            osec_d = osec_q + 6'd1;
          end
        end
        num_d = org_d;
      end
      ST_RUN: begin
        // A button edge pre-empts a coinciding tick; the prescaler stays put.
        if (act_clr) begin
          state_d = ST_SET;
          num_d   = org_q;
          presc_d = '0;
        end else if (act_ss) begin
          state_d = ST_PAUSE;
        end else if (presc_wrap) begin
          presc_d = '0;
          if (num_q != '0) begin
            tick_d = 1'b1;
            num_d  = num_q - 21'd1;
          end
          if (num_q <= 21'd1)
            state_d = ST_DONE;
        end else begin
          presc_d = presc_q + PW'(1);
        end
      end
      ST_PAUSE: begin
        if (act_clr) begin
          state_d = ST_SET;
          num_d   = org_q;
          presc_d = '0;
        end else if (act_ss) begin
          state_d = ST_RUN;
        end
      end
      default: begin
        num_d = '0;
        if (act_clr || act_ss) begin
          state_d = ST_SET;
          num_d   = org_q;
          presc_d = '0;
        end else begin
`ifdef CNTDN_AUTORELOAD_EN
          // The prescaler doubles as the DONE hold timer before reloading.
          if (presc_wrap) begin
            state_d = ST_RUN;
            num_d   = org_q;
            presc_d = '0;
          end else begin
            presc_d = presc_q + PW'(1);
          end
`else
          presc_d = presc_q;
`endif
        end
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_SET;
      org_q   <= '0;
      osec_q  <= '0;
      num_q   <= '0;
      presc_q <= '0;
      tick_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      org_q   <= org_d;
      osec_q  <= osec_d;
      num_q   <= num_d;
      presc_q <= presc_d;
      tick_q  <= tick_d;
    end
  end

  assign bus.num    = num_q;
  assign bus.org    = org_q;
  assign bus.cState = state_q;
  assign bus.tick   = tick_q;

endmodule

// File: tb/tb_cntdn_ctrl.sv
// Bench for cntdn_ctrl (TICK_DIV=4): vector table plus hand sequences, scoreboard-checked.
`timescale 1ns/1ps
module tb_cntdn_ctrl;
  localparam int TICK_DIV = 4;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  cntdn_ctrl_if bus();

  cntdn_ctrl #(.TICK_DIV(TICK_DIV), .MAX_SEC(5999)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  typedef struct {
    string       name;
    logic [1:0]  st;
    logic [20:0] num;
    logic [20:0] org;
    logic        tick;
  } exp_t;

  typedef struct {
    logic [3:0] btn;
    logic [1:0] st;
    int         num;
    int         org;
  } vec_t;

  exp_t sb_q[$];
  int   n_checks = 0;
  int   n_errors = 0;

  localparam logic [3:0] B_CLR = 4'b1000;
  localparam logic [3:0] B_SS  = 4'b0100;
  localparam logic [3:0] B_MIN = 4'b0010;
  localparam logic [3:0] B_SEC = 4'b0001;

  task automatic drive_btn(input logic [3:0] b);
    {bus.btn_clr, bus.btn_ss, bus.btn_min, bus.btn_sec} = b;
  endtask

  task automatic sb_push(input string name, input logic [1:0] st, input int num,
                         input int org, input logic tick);
    exp_t e;
    e.name = name;
    e.st   = st;
    e.num  = 21'(num);
    e.org  = 21'(org);
    e.tick = tick;
    sb_q.push_back(e);
  endtask

  task automatic sb_check();
    exp_t e;
    n_checks++;
    if (sb_q.size() == 0) begin
      n_errors++;
      $display("FAIL scoreboard_empty: got an output sample, want a queued expectation");
      return;
    end
    e = sb_q.pop_front();
    if (bus.cState !== e.st || bus.num !== e.num || bus.org !== e.org || bus.tick !== e.tick) begin
      n_errors++;
      $display("FAIL %s: got st=%0d num=%0d org=%0d tick=%0b, want st=%0d num=%0d org=%0d tick=%0b",
               e.name, bus.cState, bus.num, bus.org, bus.tick, e.st, e.num, e.org, e.tick);
    end
  endtask

  // Raise buttons at a falling edge; the action lands on the third rising edge.
  task automatic press(input string name, input logic [3:0] b, input logic [1:0] st,
                       input int num, input int org);
    @(negedge clk);
    drive_btn(b);
    sb_push(name, st, num, org, 1'b0);
    repeat (3) @(posedge clk);
    @(negedge clk);
    drive_btn(4'b0000);
    sb_check();
    $display("txn %-10s btn=%b st=%0d num=%0d org=%0d", name, b, bus.cState, bus.num, bus.org);
  endtask

  task automatic step(input string name, input logic [1:0] st, input int num,
                      input int org, input logic tick);
    sb_push(name, st, num, org, tick);
    @(negedge clk);
    sb_check();
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  vec_t vecs[14];

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    vecs[0]  = '{B_MIN,         2'd0, 60,  60};
    vecs[1]  = '{B_MIN,         2'd0, 120, 120};
    vecs[2]  = '{B_SEC,         2'd0, 121, 121};
    vecs[3]  = '{B_SEC,         2'd0, 122, 122};
    vecs[4]  = '{B_SEC,         2'd0, 123, 123};
    vecs[5]  = '{B_SEC,         2'd0, 124, 124};
    vecs[6]  = '{B_SEC,         2'd0, 125, 125};
    vecs[7]  = '{B_MIN | B_SEC, 2'd0, 185, 185};
    vecs[8]  = '{B_SS | B_MIN,  2'd1, 185, 185};
    vecs[9]  = '{B_MIN,         2'd1, 184, 185};
    vecs[10] = '{B_CLR | B_SS,  2'd0, 185, 185};
    vecs[11] = '{B_CLR | B_SS,  2'd0, 0,   0};
    vecs[12] = '{B_SS,          2'd0, 0,   0};
    vecs[13] = '{B_SEC,         2'd0, 1,   1};

    drive_btn(4'b0000);
    idle(3);
    sb_push("reset_hold", 2'd0, 0, 0, 1'b0);
    sb_check();
    rst_n = 1'b1;
    step("reset_release", 2'd0, 0, 0, 1'b0);

    for (int i = 0; i < 14; i++) begin
      press($sformatf("vec%0d", i), vecs[i].btn, vecs[i].st, vecs[i].num, vecs[i].org);
      idle(2);
    end

    // SET field arithmetic up to 99:59 and both wrap rules.
    press("clr", B_CLR, 2'd0, 0, 0); idle(2);
    for (int i = 1; i <= 99; i++) begin
      press($sformatf("min%0d", i), B_MIN, 2'd0, 60 * i, 60 * i); idle(2);
    end
    for (int i = 1; i <= 58; i++) begin
      press($sformatf("sec%0d", i), B_SEC, 2'd0, 5940 + i, 5940 + i); idle(2);
    end
    press("sec_5999", B_SEC, 2'd0, 5999, 5999); idle(2);
    press("sec_wrap", B_SEC, 2'd0, 5940, 5940); idle(2);
    press("min_wrap", B_MIN, 2'd0, 0, 0); idle(2);
    for (int i = 1; i <= 5; i++) begin
      press($sformatf("s5_%0d", i), B_SEC, 2'd0, i, i); idle(2);
    end
    for (int i = 1; i <= 99; i++) begin
      press($sformatf("m5_%0d", i), B_MIN, 2'd0, 5 + 60 * i, 5 + 60 * i); idle(2);
    end
    press("min_wrap_keep", B_MIN, 2'd0, 5, 5); idle(2);

    // Countdown from 3 to DONE.
    press("clr3", B_CLR, 2'd0, 0, 0); idle(2);
    for (int i = 1; i <= 3; i++) begin
      press($sformatf("org3_%0d", i), B_SEC, 2'd0, i, i); idle(2);
    end
    press("start3", B_SS, 2'd1, 3, 3);
    for (int k = 1; k <= 12; k++)
      step($sformatf("cd%0d", k), (k == 12) ? 2'd3 : 2'd1, 3 - k / 4, 3, (k % 4) == 0);
`ifdef CNTDN_AUTORELOAD_EN
    for (int k = 13; k <= 15; k++)
      step($sformatf("done%0d", k), 2'd3, 0, 3, 1'b0);
    step("reload", 2'd1, 3, 3, 1'b0);
    press("clr_run", B_CLR, 2'd0, 3, 3); idle(2);
`else
    for (int k = 0; k < 1000; k++)
      step("done_hold", 2'd3, 0, 3, 1'b0);
    press("ack_done", B_SS, 2'd0, 3, 3); idle(2);
`endif

    // Pause keeps the partial second.
    press("clr10", B_CLR, 2'd0, 0, 0); idle(2);
    for (int i = 1; i <= 10; i++) begin
      press($sformatf("org10_%0d", i), B_SEC, 2'd0, i, i); idle(2);
    end
    press("start10", B_SS, 2'd1, 10, 10);
    for (int k = 1; k <= 3; k++)
      step($sformatf("run10_%0d", k), 2'd1, 10, 10, 1'b0);
    press("pause", B_SS, 2'd2, 9, 10);
    for (int k = 0; k < 100; k++)
      step("paused", 2'd2, 9, 10, 1'b0);
    press("resume", B_SS, 2'd1, 9, 10);
    step("resume_p1", 2'd1, 9, 10, 1'b0);
    step("resume_tick", 2'd1, 8, 10, 1'b1);
    step("resume_p3", 2'd1, 8, 10, 1'b0);
    press("abort", B_CLR, 2'd0, 10, 10); idle(2);

    // Asynchronous reset in the middle of RUN.
    press("start_rst", B_SS, 2'd1, 10, 10);
    idle(5);
    #2;
    rst_n = 1'b0;
    #1;
    sb_push("async_reset", 2'd0, 0, 0, 1'b0);
    sb_check();
    @(negedge clk);
    rst_n = 1'b1;
    step("after_reset", 2'd0, 0, 0, 1'b0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
